mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single off-chip memory port (read channel readM1/address1/data1, write channel writeM2/address2/data2)
//  between the instruction cache (requester 0) and data cache (requester 1) of the pipelined CPU.
//  Grants one cache at a time for a whole line transaction. Routes acks/fill data to the owner only.
//  Watchdog flags lost acks. Replaces the ad-hoc owner logic in the CPU top level.
// PARAMETERS
//  WORD_SIZE     16   address / word width
//  LINE_WORDS    4    words per cache line; line width = WORD_SIZE*LINE_WORDS
//  TIMEOUT       255  max cycles in a grant without completion before timeout; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset_n      in   1     asynchronous active-low reset
//  i_rd_req     in   1     I-cache line read request (held until i_ack)
//  i_wr_req     in   1     I-cache line write request (held until i_ack)
//  i_rd_addr    in   16    I-cache read line address
//  i_wr_addr    in   16    I-cache write line address
//  i_wdata      in   64    I-cache write line
//  d_rd_req     in   1     D-cache line read request (held until d_ack)
//  d_wr_req     in   1     D-cache line write request (held until d_ack)
//  d_rd_addr    in   16    D-cache read line address
//  d_wr_addr    in   16    D-cache write line address
//  d_wdata      in   64    D-cache write line
//  i_grant      out  1     I-cache owns port
//  d_grant      out  1     D-cache owns port
//  i_ack        out  1     1-cycle pulse: I transaction complete
//  d_ack        out  1     1-cycle pulse: D transaction complete
//  rdata        out  64   fill line, valid with the owner's ack when a read was pending
//  mem_read     out  1     to readM1
//  mem_write    out  1     to writeM2
//  mem_rd_addr  out  16   to address1
//  mem_wr_addr  out  16   to address2
//  mem_wdata    out  64   to data2
//  mem_rdata    in   64   from data1
//  read_ack     in   1     memory read-done pulse
//  write_ack    in   1     memory write-done pulse
//  timeout      out  1     sticky error, set on watchdog expiry
// BEHAVIOUR
//  Reset (async): state IDLE, rd_pend=wr_pend=0, last_owner=I, cnt=0, timeout=0; all outputs 0.
//  FSM: IDLE, OWN_I, OWN_D.
//  IDLE: req_x = x_rd_req|x_wr_req. Only one requesting -> that owner next cycle. Both -> round-robin:
//   grant the one not equal to last_owner. Grant registered: request at edge t -> grant visible after t+1.
//   On entry latch rd_pend/wr_pend from owner's rd/wr req; cnt=0.
//  OWN_x: x_grant=1; mem_read=rd_pend, mem_write=wr_pend; addresses/wdata muxed from owner; others drive 0.
//   read_ack clears rd_pend; write_ack clears wr_pend; both acks same cycle clears both.
//   Acks while IDLE or for a non-pending op are ignored.
//   Completion = last pending op acked: x_ack pulses that same cycle (combinational from ack input);
//   rdata=mem_rdata registered-through when read_ack; next state IDLE; last_owner=x.
//   Min one IDLE cycle between transactions (no back-to-back grant).
//  Non-owner requests wait; never dropped; owner's ack never appears on the other ack output.
//  Watchdog: cnt increments each OWN cycle; cnt==TIMEOUT with ops pending -> timeout=1 (sticky until reset),
//   pend bits cleared, owner ack pulsed, return IDLE.
//  Owner deasserting requests before ack: protocol violation; arbiter still waits for ack/timeout.
//  Reset mid-transaction: immediate drop to IDLE; memory requests deassert asynchronously.
// STRUCTURE
//  Shared package/opcodes-style include: WORD_SIZE, LINE width, state encodings (IDLE=2'b00, OWN_I=2'b01, OWN_D=2'b10),
//   requester ids. Single module; the watchdog counter is a natural sub-module arb_watchdog (en, clr, expired).
// TESTING
//  1 i_rd_req=1 @0x0010 alone -> i_grant next cycle, mem_read=1, mem_rd_addr=0x0010; read_ack -> i_ack same cycle, rdata=mem_rdata.
//  2 i_rd_req and d_rd_req same cycle after reset (last_owner=I) -> D granted first; I granted after 1 IDLE cycle following d_ack.
//  3 d_rd_req+d_wr_req (write-back+fill) -> both mem_read/mem_write; write_ack first then read_ack 3 cycles later -> single d_ack on read_ack.
//  4 Owner I, d_rd_req asserted mid-transaction -> d_grant stays 0, mem_rd_addr stays I's; D served after i_ack.
//  5 TIMEOUT=8, grant with no acks -> after 8 OWN cycles timeout=1, owner ack pulse, IDLE; stays 1 until reset_n=0.
//  6 reset_n=0 mid-OWN_D -> grants, mem_read, mem_write 0 without clock edge; late read_ack ignored, no ack pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory port arbiter: default geometry,
// FSM state encodings, requester ids and the round-robin pick helper.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF  = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_W_DEF     = WORD_SIZE_DEF * LINE_WORDS_DEF;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // On a tie the requester that did not own the port last time wins.
  function automatic req_id_e pick_owner(input logic req_i, input logic req_d,
                                         input req_id_e last);
    if (req_i && req_d) return (last == REQ_I) ? REQ_D : REQ_I;
    return req_d ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Grant-age counter: counts cycles while the port is owned and flags expiry
// when the age reaches TIMEOUT.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single off-chip memory port between the I-cache and D-cache for
// whole line transactions, routing acks and fill data to the owner only.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_rd_req,
  input  logic                            i_wr_req,
  input  logic [WORD_SIZE-1:0]            i_rd_addr,
  input  logic [WORD_SIZE-1:0]            i_wr_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] i_wdata,
  input  logic                            d_rd_req,
  input  logic                            d_wr_req,
  input  logic [WORD_SIZE-1:0]            d_rd_addr,
  input  logic [WORD_SIZE-1:0]            d_wr_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic                            i_grant,
  output logic                            d_grant,
  output logic                            i_ack,
  output logic                            d_ack,
  output logic [WORD_SIZE*LINE_WORDS-1:0] rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_rd_addr,
  output logic [WORD_SIZE-1:0]            mem_wr_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            read_ack,
  input  logic                            write_ack,
  output logic                            timeout
);

  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  arb_state_e  state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic        wr_pend_q, wr_pend_d;
  req_id_e     last_q, last_d;
  logic        timeout_q, timeout_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic own_i, own_d, owning;
  logic rd_hit, wr_hit, rd_left, wr_left;
  logic expired, finish;
  req_id_e nxt_owner;

  assign own_i  = (state_q == OWN_I);
  assign own_d  = (state_q == OWN_D);
  assign owning = own_i | own_d;

  // Acks only count for an op the current owner still has outstanding.
  assign rd_hit  = owning & rd_pend_q & read_ack;
  assign wr_hit  = owning & wr_pend_q & write_ack;
  assign rd_left = rd_pend_q & ~rd_hit;
  assign wr_left = wr_pend_q & ~wr_hit;
  assign finish  = owning & ((~rd_left & ~wr_left) | expired);

  assign nxt_owner = pick_owner(i_rd_req | i_wr_req, d_rd_req | d_wr_req, last_q);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (owning),
    .clr_i     (~owning),
    .expired_o (expired)
  );

  // NOTE: every next-state variable gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    wr_pend_d = wr_pend_q;
    last_d    = last_q;
    timeout_d = timeout_q;
    rdata_d   = rd_hit ? mem_rdata : rdata_q;
    case (state_q)
      IDLE: begin
        if (i_rd_req | i_wr_req | d_rd_req | d_wr_req) begin
          if (nxt_owner == REQ_I) begin
            state_d   = OWN_I;
            rd_pend_d = i_rd_req;
            wr_pend_d = i_wr_req;
          end else begin
            state_d   = OWN_D;
            rd_pend_d = d_rd_req;
            wr_pend_d = d_wr_req;
          end
        end
      end
      OWN_I, OWN_D: begin
        rd_pend_d = rd_left;
        wr_pend_d = wr_left;
        if (finish) begin
          state_d   = IDLE;
          rd_pend_d = 1'b0;
          wr_pend_d = 1'b0;
          last_d    = own_i ? REQ_I : REQ_D;
          timeout_d = timeout_q | expired;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      last_q    <= REQ_I;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory-side outputs derive from registered state only, so reset drops them
  // without waiting for a clock edge.
  assign i_grant     = own_i;
  assign d_grant     = own_d;
  assign i_ack       = own_i & finish;
  assign d_ack       = own_d & finish;
  assign rdata       = rd_hit ? mem_rdata : rdata_q;
  assign mem_read    = owning & rd_pend_q;
  assign mem_write   = owning & wr_pend_q;
  assign mem_rd_addr = own_i ? i_rd_addr : (own_d ? d_rd_addr : '0);
  assign mem_wr_addr = own_i ? i_wr_addr : (own_d ? d_wr_addr : '0);
  assign mem_wdata   = own_i ? i_wdata   : (own_d ? d_wdata   : '0);
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// requester/memory traffic compared cycle by cycle against a transaction model.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_rd_req, i_wr_req, d_rd_req, d_wr_req;
  logic [15:0] i_rd_addr, i_wr_addr, d_rd_addr, d_wr_addr;
  logic [63:0] i_wdata, d_wdata, mem_rdata;
  logic        read_ack, write_ack;
  logic        i_grant, d_grant, i_ack, d_ack, mem_read, mem_write, timeout;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [63:0] rdata, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_rd_addr(i_rd_addr),
    .i_wr_addr(i_wr_addr), .i_wdata(i_wdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_rd_addr(d_rd_addr),
    .d_wr_addr(d_wr_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant), .i_ack(i_ack), .d_ack(d_ack),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .read_ack(read_ack), .write_ack(write_ack),
    .timeout(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: owner 0 = none, 1 = I-cache, 2 = D-cache.
  int          m_owner, m_last, m_age;
  bit          m_rd, m_wr, m_had_rd, m_to;
  logic [63:0] m_fill;
  int          n_owner, n_last, n_age;
  bit          n_rd, n_wr, n_had_rd, n_to;
  logic [63:0] n_fill;
  bit          exp_ia, exp_da;
  bit          agents_en, mem_en, act_i, act_d;

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_age = 0;
    m_rd = 0; m_wr = 0; m_had_rd = 0; m_to = 0; m_fill = '0;
    exp_ia = 0; exp_da = 0; act_i = 0; act_d = 0;
  endtask

  task automatic eval_and_check();
    logic [15:0] e_ra, e_wa;
    logic [63:0] e_wd;
    bit rh, wh, left_rd, left_wr, expire, ri, rq_d;
    int pick;
    n_owner = m_owner; n_last = m_last; n_age = m_age; n_rd = m_rd; n_wr = m_wr;
    n_had_rd = m_had_rd; n_to = m_to; n_fill = m_fill;
    exp_ia = 0; exp_da = 0;
    e_ra = '0; e_wa = '0; e_wd = '0;
    if (m_owner == 1) begin
      e_ra = i_rd_addr; e_wa = i_wr_addr; e_wd = i_wdata;
    end else if (m_owner == 2) begin
      e_ra = d_rd_addr; e_wa = d_wr_addr; e_wd = d_wdata;
    end
    if (m_owner != 0) begin
      rh = m_rd && read_ack;
      wh = m_wr && write_ack;
      if (rh) n_fill = mem_rdata;
      left_rd = m_rd && !rh;
      left_wr = m_wr && !wh;
      expire  = (m_age == TO);
      if (expire || (!left_rd && !left_wr)) begin
        if (m_owner == 1) exp_ia = 1; else exp_da = 1;
        if (m_had_rd && !expire) check("rdata on ack", rdata, n_fill);
        n_owner = 0; n_last = m_owner; n_rd = 0; n_wr = 0; n_age = 0;
        if (expire) n_to = 1;
      end else begin
        n_rd = left_rd; n_wr = left_wr; n_age = m_age + 1;
      end
    end else begin
      ri = i_rd_req | i_wr_req;
      rq_d = d_rd_req | d_wr_req;
      pick = 0;
      if (ri && rq_d) pick = (m_last == 1) ? 2 : 1;
      else if (ri)    pick = 1;
      else if (rq_d)  pick = 2;
      if (pick != 0) begin
        n_owner  = pick;
        n_rd     = (pick == 1) ? i_rd_req : d_rd_req;
        n_wr     = (pick == 1) ? i_wr_req : d_wr_req;
        n_had_rd = n_rd;
        n_age    = 0;
      end
    end
    check("i_grant", i_grant, 64'(m_owner == 1));
    check("d_grant", d_grant, 64'(m_owner == 2));
    check("i_ack", i_ack, 64'(exp_ia));
    check("d_ack", d_ack, 64'(exp_da));
    check("mem_read", mem_read, 64'(m_rd));
    check("mem_write", mem_write, 64'(m_wr));
    check("mem_rd_addr", mem_rd_addr, e_ra);
    check("mem_wr_addr", mem_wr_addr, e_wa);
    check("mem_wdata", mem_wdata, e_wd);
    check("timeout", timeout, 64'(m_to));
  endtask

  task automatic drive();
    int k;
    if (exp_ia) begin
      i_rd_req = 0; i_wr_req = 0; act_i = 0;
    end else if (agents_en && !act_i && $urandom_range(0, 2) == 0) begin
      k = $urandom_range(1, 3);
      i_rd_req = k[0]; i_wr_req = k[1];
      i_rd_addr = 16'($urandom); i_wr_addr = 16'($urandom);
      i_wdata = {$urandom, $urandom}; act_i = 1;
    end
    if (exp_da) begin
      d_rd_req = 0; d_wr_req = 0; act_d = 0;
    end else if (agents_en && !act_d && $urandom_range(0, 2) == 0) begin
      k = $urandom_range(1, 3);
      d_rd_req = k[0]; d_wr_req = k[1];
      d_rd_addr = 16'($urandom); d_wr_addr = 16'($urandom);
      d_wdata = {$urandom, $urandom}; act_d = 1;
    end
    mem_rdata = {$urandom, $urandom};
    if (mem_en) begin
      read_ack  = (m_rd && ($urandom_range(0, 2) == 0 || m_age >= 5)) ||
                  (!m_rd && $urandom_range(0, 7) == 0);
      write_ack = (m_wr && ($urandom_range(0, 2) == 0 || m_age >= 5)) ||
                  (!m_wr && $urandom_range(0, 7) == 0);
    end else begin
      read_ack = 0; write_ack = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge,
  // then drive the next cycle's inputs just after it.
  task automatic cycle();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    m_owner = n_owner; m_last = n_last; m_age = n_age; m_rd = n_rd; m_wr = n_wr;
    m_had_rd = n_had_rd; m_to = n_to; m_fill = n_fill;
    #1;
    drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    reset_n = 0;
    i_rd_req = 0; i_wr_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_rd_addr = '0; i_wr_addr = '0; d_rd_addr = '0; d_wr_addr = '0;
    i_wdata = '0; d_wdata = '0; mem_rdata = '0; read_ack = 0; write_ack = 0;
    agents_en = 0; mem_en = 0;
    model_reset();
    #3;
    check("reset flags", {i_grant, d_grant, i_ack, d_ack, mem_read, mem_write, timeout}, 0);
    check("reset addrs", {mem_rd_addr, mem_wr_addr}, 0);
    check("reset rdata", rdata, 0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    // Simultaneous reads after reset: D wins because I is last_owner.
    i_rd_req = 1; i_rd_addr = 16'h0100; d_rd_req = 1; d_rd_addr = 16'h0200;
    cycle();
    check("t2 d first", d_grant, 1);
    check("t2 i waits", i_grant, 0);
    check("t2 d addr", mem_rd_addr, 16'h0200);
    read_ack = 1; cycle();
    check("t2 idle gap", i_grant, 0);
    cycle();
    check("t2 i granted", i_grant, 1);
    read_ack = 1; cycle(); cycle();

    // Write-back plus fill: single ack on the later read_ack.
    d_rd_req = 1; d_wr_req = 1; d_rd_addr = 16'h0A00; d_wr_addr = 16'h0B00;
    d_wdata = 64'h1122_3344_5566_7788;
    cycle();
    check("t3 both ops", {mem_read, mem_write}, 2'b11);
    check("t3 wdata", mem_wdata, 64'h1122_3344_5566_7788);
    write_ack = 1; #1;
    check("t3 no ack on write", d_ack, 0);
    cycle(); cycle(); cycle();
    read_ack = 1; mem_rdata = 64'hCAFE_F00D_0BAD_BEEF; #1;
    check("t3 ack on read", d_ack, 1);
    check("t3 fill", rdata, 64'hCAFE_F00D_0BAD_BEEF);
    cycle(); cycle();

    // D request arrives while I owns the port.
    i_rd_req = 1; i_rd_addr = 16'h0300;
    cycle();
    d_rd_req = 1; d_rd_addr = 16'h0400;
    cycle();
    check("t4 d held off", d_grant, 0);
    check("t4 addr stays i", mem_rd_addr, 16'h0300);
    read_ack = 1; cycle();
    cycle();
    check("t4 d served", d_grant, 1);
    check("t4 d addr", mem_rd_addr, 16'h0400);
    read_ack = 1; cycle(); cycle();

    // Lone I read.
    i_rd_req = 1; i_rd_addr = 16'h0010;
    cycle();
    check("t1 grant", {i_grant, mem_read}, 2'b11);
    check("t1 addr", mem_rd_addr, 16'h0010);
    read_ack = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567; #1;
    check("t1 ack", i_ack, 1);
    check("t1 rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    cycle(); cycle();

    // Randomized traffic, then drain.
    agents_en = 1; mem_en = 1;
    repeat (3000) cycle();
    agents_en = 0;
    n = 0;
    while ((act_i || act_d || m_owner != 0) && n < 100) begin
      cycle(); n++;
    end
    cycle();
    check("drain idle", {i_grant, d_grant}, 0);
    mem_en = 0; cycle();

    // Watchdog expiry with no memory response.
    i_wr_req = 1; i_wr_addr = 16'h0777; i_wdata = 64'h5A5A;
    cycle();
    n = 0;
    while (!i_ack && n < 20) begin
      cycle(); n++;
    end
    check("t5 cycles to expiry", n, TO);
    check("t5 no ack leak", d_ack, 0);
    cycle();
    check("t5 timeout set", timeout, 1);
    check("t5 back idle", i_grant, 0);
    repeat (4) cycle();
    check("t5 timeout sticky", timeout, 1);

    // Reset in the middle of a D transaction.
    d_rd_req = 1; d_wr_req = 1; d_rd_addr = 16'h0ABC; d_wr_addr = 16'h0DEF;
    cycle();
    check("t6 owned", {d_grant, mem_read, mem_write}, 3'b111);
    #2; reset_n = 0; #1;
    check("t6 async drop", {i_grant, d_grant, mem_read, mem_write}, 0);
    check("t6 timeout cleared", timeout, 0);
    read_ack = 1;
    @(posedge clk); #1;
    check("t6 no ack in reset", d_ack, 0);
    d_rd_req = 0; d_wr_req = 0;
    @(negedge clk); reset_n = 1;
    model_reset();
    #1;
    check("t6 late ack ignored", {d_ack, i_ack, d_grant}, 0);
    @(posedge clk); #1;
    read_ack = 1;
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
